// File: rtl/addsub_pkg.sv
// Shared types and helpers for the streaming multi-word add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    RSUB = 2'd2,
    ACC  = 2'd3
  } op_e;

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_e;

  // Carry-in for the least-significant word: subtraction forms use +1 of two's complement.
  function automatic logic cin_init(op_e op);
    return (op == SUB) || (op == RSUB);
  endfunction

endpackage

// File: rtl/addsub_stream_if.sv
// Valid/ready input and output beat bundle for addsub_stream.
interface addsub_stream_if #(
  parameter int unsigned WIDTH = 8
);
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  op_e              in_op;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_carry;
  logic             out_zero;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_carry, out_zero, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_carry, out_zero, out_ovf
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational WIDTH-bit adder with optional operand inversion and MSB carry tap.
module addsub_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  input  logic             inv_x_i,
  input  logic             inv_y_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [WIDTH-1:0] xe;
  logic [WIDTH-1:0] ye;
  logic [WIDTH:0]   full;

  // Add the (optionally inverted) operands; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    xe        = inv_x_i ? ~x_i : x_i;
    ye        = inv_y_i ? ~y_i : y_i;
    full      = (WIDTH + 1)'(xe) + (WIDTH + 1)'(ye) + (WIDTH + 1)'(cin_i);
    sum_o     = full[WIDTH-1:0];
    cout_o    = full[WIDTH];
    msb_cin_o = full[WIDTH-1] ^ xe[WIDTH-1] ^ ye[WIDTH-1];
  end

endmodule

// File: rtl/addsub_stream.sv
// Streaming multi-word add/subtract/accumulate with carry chaining and one output register stage.
module addsub_stream
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  addsub_stream_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             carry_q, carry_d;
  logic             wrap_q, wrap_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic             accept;
  logic             first;
  op_e              cur_op;
  logic             zero_in;
  logic             wrap_in;
  logic             inv_x;
  logic             inv_y;
  logic [WIDTH-1:0] sl_y;
  logic             sl_cin;
  logic [WIDTH-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_msb_cin;
  logic             sum_zero;

  // Handshake and per-beat operand selection; a packet's first beat sees cleared chain state.
  always_comb begin
    in_ready = !rst && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    first    = (state_q == FIRST);
    cur_op   = first ? bus.in_op : op_q;
    zero_in  = first ? 1'b1 : zero_q;
    wrap_in  = first ? 1'b0 : wrap_q;
    inv_x    = (cur_op == SUB);
    inv_y    = (cur_op == RSUB);
    if (cur_op == ACC) begin
      sl_y   = first ? '0 : acc_q;
      sl_cin = 1'b0;
    end else begin
      sl_y   = bus.in_b;
      sl_cin = first ? cin_init(cur_op) : carry_q;
    end
  end

  addsub_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .x_i      (bus.in_a),
    .y_i      (sl_y),
    .cin_i    (sl_cin),
    .inv_x_i  (inv_x),
    .inv_y_i  (inv_y),
    .sum_o    (sl_sum),
    .cout_o   (sl_cout),
    .msb_cin_o(sl_msb_cin)
  );

  assign sum_zero = (sl_sum == '0);

  // Next state: packet FSM, chain registers and output register load/drain.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    carry_d     = carry_q;
    wrap_d      = wrap_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      state_d = bus.in_last ? FIRST : MID;
      op_d    = cur_op;
      if (cur_op == ACC) begin
        acc_d  = sl_sum;
        wrap_d = wrap_in | sl_cout;
        if (bus.in_last) begin
          out_valid_d = 1'b1;
          out_sum_d   = sl_sum;
          out_last_d  = 1'b1;
          out_carry_d = wrap_in | sl_cout;
          out_zero_d  = sum_zero;
          out_ovf_d   = 1'b0;
        end
      end else begin
        carry_d     = sl_cout;
        zero_d      = zero_in && sum_zero;
        out_valid_d = 1'b1;
        out_sum_d   = sl_sum;
        out_last_d  = bus.in_last;
        out_carry_d = bus.in_last && sl_cout;
        out_zero_d  = bus.in_last && zero_in && sum_zero;
        out_ovf_d   = bus.in_last && (sl_msb_cin ^ sl_cout);
      end
    end
  end

  // State and output registers; reset drops any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FIRST;
      op_q        <= ADD;
      carry_q     <= 1'b0;
      wrap_q      <= 1'b0;
      zero_q      <= 1'b1;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      wrap_q      <= wrap_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_addsub_stream.sv
// Self-checking bench for addsub_stream: packet-level arithmetic model plus directed literal checks.
module tb_addsub_stream;
  import addsub_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXB = 6;

  typedef struct {
    logic [W-1:0] sum;
    logic         last;
    logic         carry;
    logic         zero;
    logic         ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_rdy = 1'b0;

  int total = 0;
  int bad   = 0;

  beat_t exp_q[$];
  beat_t got_q[$];

  // packet-level model state
  op_e               pk_op;
  int                pk_n = 0;
  longint unsigned   pk_a, pk_b, pk_acc;

  logic              hold_v = 1'b0;
  logic [W+3:0]      hold_pk;

  addsub_stream_if #(.WIDTH(W)) bus();

  addsub_stream #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sx(input longint unsigned v, input int n);
    if (v[n-1]) return longint'(v) - (longint'(1) <<< n);
    return longint'(v);
  endfunction

  // Expected result of one accepted beat, derived from the whole-packet integers seen so far.
  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op,
                            input logic last);
    beat_t           e;
    int              n;
    longint unsigned mask, res;
    longint          sres, maxp, minn;
    logic            cy;
    if (pk_n == 0) begin
      pk_op = op; pk_a = 0; pk_b = 0; pk_acc = 0;
    end
    pk_a   = pk_a | (64'(a) << (pk_n * W));
    pk_b   = pk_b | (64'(b) << (pk_n * W));
    pk_acc = pk_acc + 64'(a);
    pk_n++;
    n    = pk_n * W;
    mask = (64'd1 << n) - 1;
    maxp = (longint'(1) <<< (n - 1)) - 1;
    minn = -(longint'(1) <<< (n - 1));
    res  = 0; cy = 0; sres = 0;
    case (pk_op)
      ADD: begin
        res = (pk_a + pk_b) & mask; cy = ((pk_a + pk_b) >> n) != 0;
        sres = sx(pk_a, n) + sx(pk_b, n);
      end
      SUB: begin
        res = (pk_b - pk_a) & mask; cy = pk_b >= pk_a;
        sres = sx(pk_b, n) - sx(pk_a, n);
      end
      RSUB: begin
        res = (pk_a - pk_b) & mask; cy = pk_a >= pk_b;
        sres = sx(pk_a, n) - sx(pk_b, n);
      end
      default: ;
    endcase
    if (pk_op == ACC) begin
      if (last) begin
        e.sum   = W'(pk_acc);
        e.last  = 1'b1;
        e.carry = pk_acc >= (64'd1 << W);
        e.zero  = (W'(pk_acc) == '0);
        e.ovf   = 1'b0;
        exp_q.push_back(e);
      end
    end else begin
      e.sum   = W'(res >> (n - W));
      e.last  = last;
      e.carry = last && cy;
      e.zero  = last && (res == 0);
      e.ovf   = last && ((sres > maxp) || (sres < minn));
      exp_q.push_back(e);
    end
    if (last) pk_n = 0;
  endtask

  // Compare process: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    logic [W+3:0] cur;
    beat_t        e, g;
    cur = {bus.out_sum, bus.out_last, bus.out_carry, bus.out_zero, bus.out_ovf};
    if (rst) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      exp_q.delete();
      pk_n   = 0;
      hold_v = 1'b0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (hold_v) chk("hold_stable", 64'({bus.out_valid, cur}), 64'({1'b1, hold_pk}));
      hold_v = 1'b0;
      if (bus.out_valid && exp_q.size() != 0) begin
        if (bus.out_ready) begin
          e = exp_q.pop_front();
          chk("beat", 64'(cur), 64'({e.sum, e.last, e.carry, e.zero, e.ovf}));
          g.sum = bus.out_sum; g.last = bus.out_last; g.carry = bus.out_carry;
          g.zero = bus.out_zero; g.ovf = bus.out_ovf;
          got_q.push_back(g);
        end else begin
          hold_v  = 1'b1;
          hold_pk = cur;
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_beat(bus.in_a, bus.in_b, bus.in_op, bus.in_last);
    end
  end

  // Random downstream stall pattern when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one beat (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op,
                           input logic last, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_last = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
    end
    chk("send_accept", 64'(ok), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= n) break;
      @(posedge clk);
      #1;
    end
    chk("got_count", 64'(got_q.size()), 64'(n));
  endtask

  task automatic expect_beat(input string name, input int idx, input logic [W-1:0] sum,
                             input logic last, input logic carry, input logic zero,
                             input logic ovf);
    beat_t g;
    if (idx < got_q.size()) begin
      g = got_q[idx];
      chk(name, 64'({g.sum, g.last, g.carry, g.zero, g.ovf}),
          64'({sum, last, carry, zero, ovf}));
    end else begin
      chk({name, "_present"}, 64'(got_q.size()), 64'(idx + 1));
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    int len;
    op_e op;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = ADD;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({bus.out_valid, bus.out_sum, bus.out_last, bus.out_carry,
                              bus.out_zero, bus.out_ovf, bus.in_ready}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD single beat with signed overflow
    got_q.delete();
    send_beat(8'h7F, 8'h01, ADD, 1'b1, w);
    wait_got(1);
    expect_beat("add_7f_01", 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);

    // SUB two beats (in_op on second beat must be ignored)
    got_q.delete();
    send_beat(8'h01, 8'h00, SUB, 1'b0, w);
    send_beat(8'h00, 8'h00, ACC, 1'b1, w);
    wait_got(2);
    expect_beat("sub_w0", 0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat("sub_w1", 1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // RSUB equal operands
    got_q.delete();
    send_beat(8'h34, 8'h34, RSUB, 1'b0, w);
    send_beat(8'h12, 8'h12, ADD, 1'b1, w);
    wait_got(2);
    expect_beat("rsub_w0", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat("rsub_w1", 1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // ACC four beats of 0x80: one output, wrap set, in_ready high throughout
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_beat(8'h80, 8'hFF, (i == 0) ? ACC : SUB, (i == 3), w);
      chk("acc_no_wait", 64'(w), 64'd0);
    end
    wait_got(1);
    repeat (4) @(posedge clk);
    #1;
    chk("acc_one_beat", 64'(got_q.size()), 64'd1);
    expect_beat("acc_sum", 0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Backpressure: three stalled cycles mid-packet
    got_q.delete();
    bus.out_ready = 1'b0;
    send_beat(8'h10, 8'hF0, ADD, 1'b0, w);
    bus.in_valid = 1'b1; bus.in_a = 8'h20; bus.in_b = 8'h01; bus.in_op = ADD; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_beat(8'h20, 8'h01, ADD, 1'b0, w);
    send_beat(8'h30, 8'h02, ADD, 1'b1, w);
    wait_got(3);
    expect_beat("bp_w0", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat("bp_w1", 1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat("bp_w2", 2, 8'h32, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the first beat of a 3-beat ADD packet
    got_q.delete();
    send_beat(8'h11, 8'h22, ADD, 1'b0, w);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready_now", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(8'h05, 8'h03, SUB, 1'b1, w);
    wait_got(1);
    expect_beat("post_rst_sub", 0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised packets against the model
    rand_rdy = 1'b1;
    for (int p = 0; p < 250; p++) begin
      len = $urandom_range(1, MAXB);
      op  = op_e'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(rnd_word(), rnd_word(), (i == 0) ? op : op_e'($urandom_range(0, 3)),
                  (i == len - 1), w);
      end
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_stream.md
# addsub_stream

Parametrised, multi-word streaming add/subtract unit: the sequential successor of our single-cycle 8-bit adder/subtractor. Operands of arbitrary length arrive as packets of WIDTH-bit beats, least-significant word first. The block chains carry/borrow across beats and returns registered result beats with end-of-packet flags. It sits between the pin-level input shim and the output mux, with valid/ready on both sides.

## Interface
- WIDTH, 8: beat width in bits, WIDTH ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A word.
- in_b  in  WIDTH  operand B word.
- in_op  in  2  operation; sampled on the first beat of a packet only.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result word.
- out_last  out  1  final result beat of packet.
- out_carry  out  1  final carry-out (ADD/SUB/RSUB) or wrap flag (ACC); valid only with out_last.
- out_zero  out  1  every result word of the packet was zero; valid only with out_last.
- out_ovf  out  1  signed overflow of the top word; valid only with out_last.

## Operation
- in_op encoding: ADD=0 (A+B), SUB=1 (B−A, computed as ~A+B+1), RSUB=2 (A−B), ACC=3 (wrap-around sum of all A words; B ignored).
- FSM has two states:
  - FIRST: the next accepted beat starts a packet. Latch op. Carry-in = 0 for ADD/ACC and 1 for SUB/RSUB. Clear the zero accumulator and the acc register.
  - MID: subsequent beats. Carry-in = stored carry. in_op is ignored.
  - Accepted beat with in_last=1 → FIRST. Accepted beat with in_last=0 → MID.
  - A single-beat packet (in_last on the first beat) is legal.
- ADD/SUB/RSUB: each accepted beat produces one output beat.
  - out_sum = x + y + cin, truncated to WIDTH bits. The stored carry is updated to the carry-out.
  - On the last beat: out_carry = carry-out, with 1 meaning no borrow for SUB/RSUB. out_zero = AND of per-beat (sum==0). out_ovf = carry into MSB XOR carry out of MSB.
- ACC: non-last beats produce no output.
  - acc <= acc + A, modulo 2^WIDTH. The wrap flag sets on any carry-out.
  - On the last beat, emit exactly one beat: out_sum = acc + A, out_last=1, out_carry = wrap flag including this beat, out_zero = (out_sum==0), out_ovf=0.
- out_last copies in_last of the producing beat, and is always 1 for ACC.
- Flag outputs hold 0 on non-last beats.

## Timing
- One output register stage. Latency is 1 cycle from input acceptance to out_valid.
- in_ready = !rst && (!out_valid || out_ready). In the steady state this gives full throughput of one beat per cycle.
- out_valid stays asserted and all out_* stay stable until out_ready is high.
- Non-last ACC beats are accepted whenever in_ready is high. They do not load the output register.
- Simultaneous output pop and input accept in the same cycle: the register reloads and out_valid stays 1.
- Reset values:
  - out_valid=0, out_sum=0, out_last=0, out_carry=0, out_zero=0, out_ovf=0.
  - FSM=FIRST, carry=0, acc=0, wrap=0, zero accumulator=1.
  - in_ready=0 while rst is high.
- Reset mid-packet discards the partial packet. The first accepted beat after reset starts a new packet.

## Structure
- Package addsub_pkg:
  - op_e enum (ADD, SUB, RSUB, ACC).
  - state_e enum (FIRST, MID).
  - Function cin_init(op_e).
- Sub-module addsub_slice: combinational WIDTH-bit adder.
  - Inputs: x, y, cin, and invert-x / invert-y controls.
  - Outputs: sum, cout, msb_cin.
- The top module holds the FSM, the carry/acc/zero/wrap registers and the output register.

## Test plan
- WIDTH=8, ADD single beat A=0x7F, B=0x01 → 1 cycle later out_sum=0x80, last=1, carry=0, zero=0, ovf=1.
- SUB two beats, A words {0x01,0x00}, B words {0x00,0x00} → out_sum 0xFF then 0xFF; on last beat carry=0 (borrow), ovf=0.
- RSUB two beats, A={0x34,0x12}, B={0x34,0x12} → 0x00, 0x00; on last beat zero=1, carry=1.
- ACC four beats, A=0x80 each → exactly one output beat: sum=0x00, last=1, carry=1, zero=1. in_ready high on all four beats.
- Backpressure: out_ready=0 for 3 cycles during an ADD packet → in_ready low, output held stable; on release no beat is lost or duplicated.
- Assert rst after the first beat of a 3-beat ADD packet → out_valid=0 immediately. The next beat starts a new packet with cin=0, and op is re-sampled.
